sram_like_mem_responder: RTL
============================

Name: sram_like_mem_responder

Overview:
- Slave (responder) side of the core's SRAM-like request/response bus (req/addr_ok/data_ok) used by the instruction and data ports.
- Backs the bus with an internal word-organised memory.
- Accepts one request per cycle and returns responses in order after a fixed minimum latency.
- Supports address-channel and response-channel stall injection for bench use and for modelling slow memory behind the cache-less core.

Parameters:
ADDR_BITS, 12, number of word-index bits; memory holds 2^ADDR_BITS 32-bit words
LATENCY, 2, minimum cycles from acceptance cycle to data_ok; legal range 1..15
DEPTH, 4, outstanding-request queue entries; power of 2, at least 2

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-low
req  in  1  request valid from initiator
wr  in  1  1 = write, 0 = read
wstrb  in  4  byte write enables; bit i writes wdata[8i+7:8i]
addr  in  32  byte address; addr[ADDR_BITS+1:2] selects the word
size  in  3  transfer size; recorded only, no effect on the memory access
wdata  in  32  write data
rdata  out  32  read data, valid while data_ok=1
addr_ok  out  1  request accepted this cycle when req && addr_ok
data_ok  out  1  one response completes this cycle
addr_stall  in  1  forces addr_ok=0
resp_stall  in  1  forces data_ok=0; response is held
outstanding  out  log2(DEPTH)+1  accepted requests not yet responded

Behaviour:
- Reset: resetn sampled at posedge. Queue is emptied and all in-flight requests are discarded.
  - Outputs during and after reset: outstanding=0, data_ok=0, rdata=0.
  - addr_ok=0 while resetn=0; addr_ok=1 from the first cycle after reset if addr_stall=0.
  - Memory contents are not reset.
- Acceptance:
  - addr_ok = resetn && !addr_stall && (count < DEPTH). It uses the registered count only; a same-cycle retire does not open a slot.
  - A request is accepted at the posedge where req && addr_ok.
  - addr_ok may be high with req low. The initiator may hold req across stalled cycles; no acceptance occurs until addr_ok=1.
- Memory access at acceptance edge:
  - Write: for each i with wstrb[i]=1, mem[idx] byte i <= wdata byte i. wstrb=0 is a legal no-op write and still produces a response.
  - Read: the queue entry captures mem[idx] as seen at that edge, i.e. including all previously accepted writes.
  - Address bits above ADDR_BITS+1 and bits [1:0] are ignored, so addresses alias modulo 2^(ADDR_BITS+2).
- Queue entry contents: {is_write, data, age}.
  - age is set to 1 on the acceptance edge, then increments each cycle, saturating at LATENCY.
- Response:
  - data_ok = (count != 0) && head.age == LATENCY && !resp_stall.
  - rdata = head.data for reads, 0 for writes, and 0 when data_ok=0.
  - The head retires at the posedge where data_ok=1. At most one response per cycle, strictly in acceptance order.
  - Minimum latency: accepted at edge ending cycle T gives data_ok in cycle T+LATENCY.
- Simultaneous accept and retire in one cycle: count is unchanged; the pointers wrap modulo DEPTH independently.
- Full queue (count == DEPTH):
  - addr_ok=0 for that whole cycle, even if a retire occurs in it.
  - addr_ok reasserts the cycle after count drops.
- Back-to-back responses: entries behind the head keep aging while the head is stalled. After resp_stall falls, data_ok stays high on consecutive cycles while heads are ready.
- outstanding = count, registered.

Test Plan:
- Reset then single write:
  - Stimulus: addr=0x100, wdata=0xDEADBEEF, wstrb=4'hF, LATENCY=2.
  - Required: addr_ok=1 in the request cycle; data_ok=1 exactly 2 cycles later with rdata=0; outstanding goes 0->1->0.
- Partial write then read:
  - Stimulus: write 0x11223344 to 0x100 with wstrb=4'b0101; next cycle read 0x100.
  - Required: read response rdata=0xDE22BE44, in order, one cycle after the write's data_ok.
- Queue full, DEPTH=4:
  - Stimulus: resp_stall=1, 5 back-to-back read requests.
  - Required: 4 accepted, addr_ok=0 on the 5th, outstanding=4.
  - Then drop resp_stall: 4 consecutive data_ok pulses; 5th request accepted the cycle after the first retire.
- Address stall:
  - Stimulus: addr_stall=1 for 3 cycles with req held.
  - Required: no acceptance, no memory change, outstanding=0; accepted on the first cycle addr_stall=0.
- Aliasing and latency:
  - Stimulus: ADDR_BITS=4, LATENCY=1; write 0xA5A5A5A5 to 0x40, read 0x00.
  - Required: rdata=0xA5A5A5A5; each data_ok 1 cycle after its accept.
- Reset mid-operation:
  - Stimulus: 3 outstanding reads, resetn=0 for one cycle.
  - Required: data_ok stays 0, outstanding=0; memory retains its prior contents, verified by a read after reset.

Source files
------------

// File: rtl/sram_like_mem_responder.sv
// Responder side of the SRAM-like req/addr_ok/data_ok bus, backed by an internal word memory.
// Latency: data_ok no earlier than LATENCY cycles after the accepting edge; responses strictly in order.
// Backpressure: addr_ok drops when the queue is full or addr_stall=1; resp_stall holds the head response.
//
// Ports:
//   clk, resetn       clock and synchronous active-low reset
//   req, wr, wstrb,   request channel; a request is taken at the posedge where req && addr_ok
//   addr, size, wdata
//   addr_ok           request slot available this cycle
//   data_ok, rdata    one in-order response this cycle; rdata is 0 for writes and when idle
//   addr_stall        forces addr_ok low
//   resp_stall        forces data_ok low and holds the head entry
//   outstanding       registered count of accepted but not yet responded requests
module sram_like_mem_responder #(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 2,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         req,
  input  logic                         wr,
  input  logic [3:0]                   wstrb,
  input  logic [31:0]                  addr,
  input  logic [2:0]                   size,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata,
  output logic                         addr_ok,
  output logic                         data_ok,
  input  logic                         addr_stall,
  input  logic                         resp_stall,
  output logic [$clog2(DEPTH):0]       outstanding
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int WORDS = 1 << ADDR_BITS;

  // Word memory; deliberately not reset so contents survive a mid-run reset.
  logic [31:0] mem [WORDS];

  // Outstanding-request queue, one entry per accepted request.
  logic        q_wr   [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [3:0]  q_age  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [ADDR_BITS-1:0] idx;
  logic                 accept;
  logic                 retire;

  // Byte offset, bits above the word index and the size code do not affect the access.
  logic unused_addr_size;
  assign unused_addr_size = ^{size, addr[31:ADDR_BITS+2], addr[1:0]};

  assign idx = addr[ADDR_BITS+1:2];

  // Only the registered count gates acceptance, so a retire in the same
  // cycle never opens a slot early.
  assign addr_ok = resetn && !addr_stall && (count < CW'(DEPTH));
  assign accept  = req && addr_ok;

  assign data_ok = resetn && (count != '0) && (q_age[rd_ptr] == 4'(LATENCY)) && !resp_stall;
  assign retire  = data_ok;

  always_comb begin
    rdata = 32'h0;
    if (data_ok && !q_wr[rd_ptr]) begin
      rdata = q_data[rd_ptr];
    end
  end

  assign outstanding = count;

  // Memory write port: byte-enabled write at the accepting edge.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Queue control. Reads capture the pre-edge memory word, which already
  // contains every earlier accepted write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_age[i] <= 4'd0;
      end
    end else begin
      // Every entry ages, saturating at LATENCY; entries behind a stalled
      // head therefore become ready and drain back to back. Free slots age
      // too, which is harmless because acceptance reloads the age.
      for (int i = 0; i < DEPTH; i++) begin
        if (q_age[i] < 4'(LATENCY)) begin
          q_age[i] <= q_age[i] + 4'd1;
        end
      end

      if (accept) begin
        q_wr[wr_ptr]   <= wr;
        q_data[wr_ptr] <= wr ? 32'h0 : mem[idx];
        q_age[wr_ptr]  <= 4'd1;
        wr_ptr         <= wr_ptr + PW'(1);
      end

      if (retire) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({accept, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
